hazard_stall_ctrl_320: RTL

Pipeline hazard controller that drives the stall/flush inputs of the IF–ID register and the PC write enable. It detects load-use hazards between ID and EX, holds the front end for multi-cycle multiply/divide operations, and squashes the fetched instruction after a taken branch. It is a posedge-clocked Moore FSM, so its outputs are stable before the IF–ID register captures on the following negedge.

---
 rtl/hazard_stall_ctrl_320_if.sv | 38 +++
 rtl/hazard_stall_ctrl_320.sv | 128 ++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl_320_if.sv
// Handshake bundle between the pipeline and hazard_stall_ctrl_320.
// HAZARD_STATS_EN adds the stall/flush statistics outputs.
interface hazard_stall_ctrl_320_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic        ex_memread;
    logic [4:0]  ex_rd;
    logic        ex_branch_taken;
    logic        ex_muldiv_start;
    logic [1:0]  bubble;
    logic        pc_write;
    logic        idex_flush;
    logic        busy;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt,
        output ex_memread, ex_rd, ex_branch_taken, ex_muldiv_start,
        input  bubble, pc_write, idex_flush, busy
`ifdef HAZARD_STATS_EN
        , input stall_cycles, flush_count
`endif
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt,
        input  ex_memread, ex_rd, ex_branch_taken, ex_muldiv_start,
        output bubble, pc_write, idex_flush, busy
`ifdef HAZARD_STATS_EN
        , output stall_cycles, flush_count
`endif
    );
endinterface

// File: rtl/hazard_stall_ctrl_320.sv
// Moore hazard controller driving IF-ID stall/flush, PC write and ID-EX flush.
// Optional HAZARD_STATS_EN adds saturating stall-cycle and flush counters.
module hazard_stall_ctrl_320 #(
    parameter int MULDIV_LAT = 32,
    parameter int CNT_W      = 6
) (
    input  logic                     clk,
    input  logic                     regReset,
    hazard_stall_ctrl_320_if.slave   bus
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        MD_STALL = 2'd2,
        FLUSH    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               lu_s;
    logic [1:0]         bubble_q;
    logic               pc_write_q;
    logic               idex_flush_q;
    logic               busy_q;

    // Load-use detection; $0 is hard-wired and never a real producer
    always_comb begin
        lu_s = 1'b0;
        if (bus.ex_memread && (bus.ex_rd != 5'd0)) begin
            lu_s = (bus.id_use_rs && (bus.id_rs == bus.ex_rd)) ||
                   (bus.id_use_rt && (bus.id_rt == bus.ex_rd));
        end else begin
            lu_s = 1'b0;
        end
    end

    // Next-state logic; new hazards are only accepted from RUN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (bus.ex_branch_taken) begin
                    state_d = FLUSH;
                end else if (bus.ex_muldiv_start) begin
                    state_d = MD_STALL;
                    cnt_d   = CNT_W'(MULDIV_LAT - 1);
                end else if (lu_s) begin
                    state_d = LD_STALL;
                end else begin
                    state_d = RUN;
                end
            end
            LD_STALL: state_d = RUN;
            FLUSH:    state_d = RUN;
            MD_STALL: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter and Moore outputs registered from the next state
    always_ff @(posedge clk or posedge regReset) begin
        if (regReset) begin
            state_q      <= RUN;
            cnt_q        <= {CNT_W{1'b0}};
            bubble_q     <= 2'b00;
            pc_write_q   <= 1'b1;
            idex_flush_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            case (state_d)
                RUN: begin
                    bubble_q <= 2'b00; pc_write_q <= 1'b1; idex_flush_q <= 1'b0; busy_q <= 1'b0;
                end
                LD_STALL, MD_STALL: begin
                    bubble_q <= 2'b01; pc_write_q <= 1'b0; idex_flush_q <= 1'b1; busy_q <= 1'b1;
                end
                FLUSH: begin
                    bubble_q <= 2'b10; pc_write_q <= 1'b1; idex_flush_q <= 1'b1; busy_q <= 1'b1;
                end
                default: begin
                    bubble_q <= 2'b00; pc_write_q <= 1'b1; idex_flush_q <= 1'b0; busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bubble     = bubble_q;
    assign bus.pc_write   = pc_write_q;
    assign bus.idex_flush = idex_flush_q;
    assign bus.busy       = busy_q;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cycles_q;
    logic [15:0] flush_count_q;

    // Saturating statistics: cycles spent holding IF-ID, and FLUSH entries
    always_ff @(posedge clk or posedge regReset) begin
        if (regReset) begin
            stall_cycles_q <= 16'd0;
            flush_count_q  <= 16'd0;
        end else begin
            if ((bubble_q == 2'b01) && (stall_cycles_q != 16'hFFFF)) begin
                stall_cycles_q <= stall_cycles_q + 16'd1;
            end
            if ((state_q == RUN) && (state_d == FLUSH) && (flush_count_q != 16'hFFFF)) begin
                flush_count_q <= flush_count_q + 16'd1;
            end
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
    assign bus.flush_count  = flush_count_q;
`endif

endmodule
